// File: rtl/downsampler_pkg.sv
// Sampling constants shared by the downsampler and the upsampler,
// plus the rounding helper used to average a 2x2 pixel block.
package downsampler_pkg;

    localparam int DEF_IN_WIDTH  = 800;
    localparam int DEF_IN_HEIGHT = 600;
    localparam int CNT_W         = 10;
    localparam int PIX_W         = 8;
    localparam int HSUM_W        = 9;
    localparam int TOTAL_W       = 10;

    // Largest block sum is 1020, so adding 2 still fits in TOTAL_W bits.
    function automatic logic [PIX_W-1:0] round_quarter(input logic [TOTAL_W-1:0] total);
        logic [TOTAL_W-1:0] biased;
        biased = total + 10'd2;
        return biased[TOTAL_W-1:2];
    endfunction

endpackage

// File: rtl/downsampler_line_buffer.sv
// Single-port-write, synchronous-read line buffer holding horizontal pair sums
// of the previous even row. Contents are intentionally not reset.
module line_buffer #(
    parameter int DEPTH = 400,
    parameter int WIDTH = 9,
    parameter int AW    = 9
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage write and registered read; read data holds until the next read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/downsampler.sv
// 2x2 box-filter downsampler: averages each 2x2 input block (round-half-up)
// and writes one pixel per block into the downstream FIFO.
module downsampler
    import downsampler_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int IN_HEIGHT = DEF_IN_HEIGHT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic             fifo_full,
    output logic             fifo_write,
    output logic [7:0]       dataout,
    output logic [9:0]       current_rowcount,
    output logic [9:0]       current_colcount,
    output logic             overflow,
    output logic             frame_done
);

    localparam int LB_DEPTH = IN_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [PIX_W-1:0]   held_q, held_d;
    logic               out_valid_q, out_valid_d;
    logic [PIX_W-1:0]   dataout_q, dataout_d;
    logic               overflow_q, overflow_d;
    logic               frame_done_q, frame_done_d;

    logic               col_last_s;
    logic               row_last_s;
    logic [HSUM_W-1:0]  hsum_s;
    logic [TOTAL_W-1:0] total_s;
    logic [LB_AW-1:0]   lb_addr_s;
    logic               lb_wr_en_s;
    logic               lb_rd_en_s;
    logic [HSUM_W-1:0]  lb_rd_data_s;

    // Even rows store pair sums; odd rows fetch them on the even-column pixel.
    line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (HSUM_W),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clock   (clock),
        .wr_en   (lb_wr_en_s),
        .wr_addr (lb_addr_s),
        .wr_data (hsum_s),
        .rd_en   (lb_rd_en_s),
        .rd_addr (lb_addr_s),
        .rd_data (lb_rd_data_s)
    );

    // Next-state logic for counters, pair holding, output pixel and flags.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        held_d       = held_q;
        col_last_s   = (col_q == CNT_W'(IN_WIDTH - 1));
        row_last_s   = (row_q == CNT_W'(IN_HEIGHT - 1));
        hsum_s       = {1'b0, held_q} + {1'b0, data};
        total_s      = {1'b0, lb_rd_data_s} + {1'b0, hsum_s};
        lb_addr_s    = LB_AW'(col_q >> 1);
        lb_wr_en_s   = valid & ~row_q[0] & col_q[0];
        lb_rd_en_s   = valid & row_q[0] & ~col_q[0];

        if (valid) begin
            if (!col_q[0]) begin
                held_d = data;
            end else begin
                held_d = held_q;
            end
            if (col_last_s) begin
                col_d = '0;
                if (row_last_s) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
                row_d = row_q;
            end
        end else begin
            col_d  = col_q;
            row_d  = row_q;
            held_d = held_q;
        end

        out_valid_d = valid & row_q[0] & col_q[0];
        if (out_valid_d) begin
            dataout_d = round_quarter(total_s);
        end else begin
            dataout_d = dataout_q;
        end

        overflow_d   = overflow_q | (out_valid_q & fifo_full);
        frame_done_d = valid & col_last_s & row_last_s;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            held_q       <= '0;
            out_valid_q  <= 1'b0;
            dataout_q    <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            held_q       <= held_d;
            out_valid_q  <= out_valid_d;
            dataout_q    <= dataout_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo_write       = out_valid_q & ~fifo_full;
    assign dataout          = dataout_q;
    assign current_rowcount = row_q;
    assign current_colcount = col_q;
    assign overflow         = overflow_q;
    assign frame_done       = frame_done_q;

endmodule

// File: doc/downsampler.md
DOWNSAMPLER -- requirements
Module: downsampler

Interface
REQ-001 The block SHALL expose parameter IN_WIDTH, default 800, meaning input pixels per row (even, at most 1024).
REQ-002 The block SHALL expose parameter IN_HEIGHT, default 600, meaning input rows per frame (even, at most 1024).
REQ-003 clock  input  1  the single clock; all state SHALL change only on its rising edge, except at reset.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid  input  1  one input pixel is present on data this cycle; there is no input backpressure.
REQ-006 data  input  8  input pixel, raster order.
REQ-007 fifo_full  input  1  the downstream FIFO feeding the upsampler cannot accept a write.
REQ-008 fifo_write  output  1  one-cycle write strobe into the downstream FIFO.
REQ-009 dataout  output  8  downsampled pixel, valid while fifo_write=1.
REQ-010 current_rowcount  output  10  input row of the next expected pixel.
REQ-011 current_colcount  output  10  input column of the next expected pixel.
REQ-012 overflow  output  1  sticky flag: at least one output pixel was dropped because of fifo_full.
REQ-013 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 Each cycle with valid=1, the block SHALL consume one pixel; cycles with valid=0 SHALL leave all state unchanged, including in the middle of a pixel pair.
REQ-015 The column counter SHALL increment per accepted pixel and wrap from IN_WIDTH-1 to 0; on that wrap the row counter SHALL increment.
REQ-016 The row counter SHALL wrap from IN_HEIGHT-1 to 0, and frame_done SHALL pulse for exactly the following cycle.
REQ-017 At an even column, the block SHALL hold the pixel; at the following odd column it SHALL form hsum = held + data, 9 bits, with no truncation.
REQ-018 On even rows, hsum SHALL be written to the line buffer at address col>>1; no output is produced.
REQ-019 On odd rows, the line buffer SHALL be read at address col>>1 when the even-column pixel is accepted, so the data is available at the paired odd-column pixel.
REQ-020 On odd rows at an odd column, total = linebuf + hsum (10 bits), and the output pixel SHALL be (total + 2) >> 2, i.e. round-half-up.
REQ-021 The output SHALL be registered: dataout and an internal out_valid SHALL update 1 cycle after the odd-row, odd-column pixel is accepted; latency is 1 cycle.
REQ-022 fifo_write SHALL equal out_valid AND NOT fifo_full; if out_valid=1 and fifo_full=1, the pixel SHALL be dropped and overflow set.
REQ-023 overflow SHALL remain 1 until reset, and processing SHALL continue normally after a drop.
REQ-024 The block SHALL produce exactly (IN_WIDTH/2)*(IN_HEIGHT/2) fifo_write opportunities per frame.
REQ-025 dataout SHALL hold its last value when fifo_write=0.

Reset
REQ-026 While reset=0, the block SHALL clear the counters, the held pixel, out_valid, fifo_write, dataout, overflow and frame_done to 0 immediately, without waiting for a clock edge.
REQ-027 Line buffer contents SHALL NOT be cleared; correctness follows because each even row rewrites every entry before the next odd row reads it.
REQ-028 After reset is released mid-frame, the next accepted pixel SHALL be treated as row 0, column 0.

Structure
REQ-029 IN_WIDTH and IN_HEIGHT defaults and the count width (10) SHALL live in the shared sampling constants file used by the upsampler.
REQ-030 The line buffer SHALL be a sub-module line_buffer: depth IN_WIDTH/2, 9-bit width, 1 write port, 1 synchronous read port, 1-cycle read latency, no reset.

Verification
REQ-031 Frame of constant 100, valid always 1 -> 120000 fifo_write pulses, all dataout=100, frame_done pulses once, 1 cycle after pixel 480000.
REQ-032 2x2 blocks {1,2,3,4} -> 3; {0,0,0,2} -> 1; {0,0,0,1} -> 0; {255,255,255,255} -> 255, with no 10-bit overflow.
REQ-033 fifo_full=1 during a single output cycle -> that fifo_write=0, overflow=1 thereafter, and the next output is written normally.
REQ-034 Same frame with random valid gaps, including gaps between pair pixels and across row ends -> output sequence identical to the gapless run.
REQ-035 reset=0 asserted at row 101, column 37 -> outputs and counters go to 0 before the next edge; the following full frame meets REQ-031.
REQ-036 Counter boundaries: column 799 -> 0 with row increment; row 599, column 799 -> both 0 and frame_done=1 for 1 cycle.
